// File: rtl/db4_interp.sv
// DB4 polyphase 2x interpolating synthesis stage: each accepted sample yields an
// even-branch output followed by an odd-branch output, using shift-add coefficients.
module db4_interp #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 9,
    parameter int ACC_W = 18,
    parameter int SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] acc_dbg
);

    typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    state_t state, state_nxt;
    logic signed [IN_W-1:0]  x_cur, x_prev;
    logic signed [ACC_W-1:0] acc_e_new, acc_o;
    logic                    load_in, load_odd;

    function automatic logic signed [ACC_W-1:0] sx(input logic signed [IN_W-1:0] v);
        return {{(ACC_W-IN_W){v[IN_W-1]}}, v};
    endfunction

    // Coefficients decomposed as 124=128-4, 57=64-8+1, 214=256-32-8-2, 33=32+1.
    function automatic logic signed [ACC_W-1:0] mul124(input logic signed [ACC_W-1:0] v);
        return (v <<< 7) - (v <<< 2);
    endfunction

    function automatic logic signed [ACC_W-1:0] mul57(input logic signed [ACC_W-1:0] v);
        return (v <<< 6) - (v <<< 3) + v;
    endfunction

    function automatic logic signed [ACC_W-1:0] mul214(input logic signed [ACC_W-1:0] v);
        return (v <<< 8) - (v <<< 5) - (v <<< 3) - (v <<< 1);
    endfunction

    function automatic logic signed [ACC_W-1:0] mul33(input logic signed [ACC_W-1:0] v);
        return (v <<< 5) + v;
    endfunction

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
        else if (s < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        else                  return s[OUT_W-1:0];
    endfunction

    // Even branch sees the incoming sample as x[n] and the held x_cur as x[n-1].
    assign acc_e_new = mul124(sx(in_data)) + mul57(sx(x_cur));
    assign acc_o     = mul214(sx(x_cur)) - mul33(sx(x_prev));
    assign out_valid = (state != IDLE);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load_in   = 1'b0;
        load_odd  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_in   = 1'b1;
                    state_nxt = EVEN;
                end
            end
            EVEN: begin
                if (out_ready) begin
                    load_odd  = 1'b1;
                    state_nxt = ODD;
                end
            end
            ODD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load_in   = 1'b1;
                        state_nxt = EVEN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            in_ready  = 1'b0;
            load_in   = 1'b0;
            load_odd  = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            x_cur    <= '0;
            x_prev   <= '0;
            out_data <= '0;
            acc_dbg  <= '0;
        end else if (clear) begin
            state    <= IDLE;
            x_cur    <= '0;
            x_prev   <= '0;
            out_data <= '0;
            acc_dbg  <= '0;
        end else begin
            state <= state_nxt;
            if (load_in) begin
                x_prev   <= x_cur;
                x_cur    <= in_data;
                out_data <= sat(acc_e_new);
                acc_dbg  <= acc_e_new;
            end else if (load_odd) begin
                out_data <= sat(acc_o);
                acc_dbg  <= acc_o;
            end
        end
    end

endmodule

// File: tb/tb_db4_interp.sv
// Bench for db4_interp: table vectors plus a scoreboard, with a SHIFT=6 twin for saturation.
module tb_db4_interp;

    logic clk = 1'b0;
    logic reset, clear, in_valid, out_ready;
    logic signed [8:0]  in_data;
    logic               in_ready, out_valid, in_ready6, out_valid6;
    logic signed [8:0]  out_data, out_data6;
    logic signed [17:0] acc_dbg, acc_dbg6;

    always #5 clk = ~clk;

    db4_interp dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .acc_dbg(acc_dbg)
    );

    db4_interp #(.SHIFT(6)) dut6 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready6),
        .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready),
        .acc_dbg(acc_dbg6)
    );

    typedef struct { int d; int a; } exp_t;
    typedef struct { int x; int oe; int oo; int ae; int ao; } vec_t;

    exp_t sb[$];
    exp_t sb6[$];
    exp_t drv_e, drv_o;
    int   checks = 0, errors = 0;
    int   h_cur = 0, m6_cur = 0;
    bit   t_acc, t_ov, t_ir;
    int   t_od;

    function automatic int acc_m(int x, int xp, bit odd);
        return odd ? (214 * x - 33 * xp) : (124 * x + 57 * xp);
    endfunction

    function automatic int sat_m(int a, int sh);
        int v;
        v = a >>> sh;
        if (v > 255)  v = 255;
        if (v < -256) v = -256;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: sample on the falling edge, score handshakes, return just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        t_acc = in_valid && in_ready;
        t_ov  = out_valid;
        t_ir  = in_ready;
        t_od  = int'(out_data);
        if (reset || clear) begin
            sb.delete();
            sb6.delete();
            m6_cur = 0;
            t_acc  = 1'b0;
        end else begin
            if (t_acc) begin
                sb.push_back(drv_e);
                sb.push_back(drv_o);
                sb6.push_back('{sat_m(acc_m(int'(in_data), m6_cur, 0), 6), acc_m(int'(in_data), m6_cur, 0)});
                sb6.push_back('{sat_m(acc_m(int'(in_data), m6_cur, 1), 6), acc_m(int'(in_data), m6_cur, 1)});
                m6_cur = int'(in_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", int'(out_data), -9999);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", int'(out_data), e.d);
                    chk("acc_dbg", int'(acc_dbg), e.a);
                end
            end
            if (out_valid6 && out_ready) begin
                if (sb6.size() == 0) begin
                    chk("sb6_unexpected_output", int'(out_data6), -9999);
                end else begin
                    e = sb6.pop_front();
                    chk("sat_out_data", int'(out_data6), e.d);
                    chk("sat_acc_dbg", int'(acc_dbg6), e.a);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(int x, int oe, int oo, int ae, int ao, bit chk_ov, output int waits);
        in_data  = 9'(x);
        in_valid = 1'b1;
        drv_e    = '{oe, ae};
        drv_o    = '{oo, ao};
        waits    = 0;
        do begin
            tick();
            waits++;
            if (chk_ov) chk("no_bubble_out_valid", int'(t_ov), 1);
        end while (!t_acc && waits < 50);
        if (!t_acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        h_cur    = x;
    endtask

    task automatic send_m(int x);
        int w;
        send(x, sat_m(acc_m(x, h_cur, 0), 8), sat_m(acc_m(x, h_cur, 1), 8),
             acc_m(x, h_cur, 0), acc_m(x, h_cur, 1), 1'b0, w);
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (!out_valid && sb.size() == 0 && sb6.size() == 0) break;
            tick();
        end
        chk("drain_sb_empty", sb.size() + sb6.size(), 0);
        chk("out_valid_dropped", int'(out_valid), 0);
    endtask

    vec_t vecs[7];

    initial begin
        int w, p, ev;
        vecs[0] = '{100,   48,   83,  12400,  21400};
        vecs[1] = '{0,     22,  -13,   5700,  -3300};
        vecs[2] = '{255,  123,  213,  31620,  54570};
        vecs[3] = '{255,  180,  180,  46155,  46155};
        vecs[4] = '{255,  180,  180,  46155,  46155};
        vecs[5] = '{-256, -68, -247, -17209, -63199};
        vecs[6] = '{-256, -181, -181, -46336, -46336};

        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_acc_dbg", int'(acc_dbg), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Impulse, then a continuous stream (255 x3, -256 x2).
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].x, vecs[i].oe, vecs[i].oo, vecs[i].ae, vecs[i].ao, (i >= 3), w);
            if (i == 0 || i == 2) chk("first_accept_wait", w, 1);
            else                  chk("in_ready_toggle_wait", w, 2);
            if (i == 1) drain();
        end
        drain();

        // Backpressure in EVEN: output frozen, new sample refused, nothing lost.
        out_ready = 1'b0;
        p = h_cur;
        send_m(77);
        ev = sat_m(acc_m(77, p, 0), 8);
        in_valid = 1'b1; in_data = -9'sd5;
        drv_e = '{sat_m(acc_m(-5, 77, 0), 8), acc_m(-5, 77, 0)};
        drv_o = '{sat_m(acc_m(-5, 77, 1), 8), acc_m(-5, 77, 1)};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_in_ready", int'(t_ir), 0);
            chk("bp_hold_data", t_od, ev);
            chk("bp_out_valid", int'(t_ov), 1);
        end
        out_ready = 1'b1;
        tick();
        tick();
        chk("bp_accept_in_odd", int'(t_acc), 1);
        in_valid = 1'b0; h_cur = -5;
        drain();

        // Asynchronous reset while presenting the odd output, input held valid.
        send_m(50);
        in_valid = 1'b1; in_data = 9'sd60;
        drv_e = '{sat_m(acc_m(60, 50, 0), 8), acc_m(60, 50, 0)};
        drv_o = '{sat_m(acc_m(60, 50, 1), 8), acc_m(60, 50, 1)};
        tick();
        #1 reset = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_acc_dbg", int'(acc_dbg), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        tick();
        reset = 1'b0; in_valid = 1'b0; h_cur = 0;
        send(100, 48, 83, 12400, 21400, 1'b0, w);
        drain();

        // clear together with in_valid in ODD: input refused, history zeroed.
        send_m(-40);
        in_valid = 1'b1; in_data = 9'sd90;
        drv_e = '{sat_m(acc_m(90, -40, 0), 8), acc_m(90, -40, 0)};
        drv_o = '{sat_m(acc_m(90, -40, 1), 8), acc_m(90, -40, 1)};
        tick();
        clear = 1'b1;
        tick();
        chk("clr_in_ready", int'(t_ir), 0);
        clear = 1'b0; in_valid = 1'b0; h_cur = 0;
        tick();
        chk("clr_idle_out_valid", int'(t_ov), 0);
        chk("clr_out_data", t_od, 0);
        send(100, 48, 83, 12400, 21400, 1'b0, w);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
